// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
// Shared definitions for the ALU issue sequencer and anything that talks to it:
//   - alu_ctrl_e   : 4-bit ALU control codes understood by the 16-bit ALU
//   - seq_state_e  : sequencer FSM state encoding
//   - is_muldiv()  : true for the two multi-cycle operations (MUL, DIV)
//   - is_illegal() : true for the reserved control code
package alu_op_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_AND     = 4'b0010,
    ALU_OR      = 4'b0011,
    ALU_XOR     = 4'b0100,
    ALU_SLL     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_NOT     = 4'b0111,
    ALU_MUL     = 4'b1000,
    ALU_DIV     = 4'b1001,
    ALU_INC     = 4'b1010,
    ALU_DEC     = 4'b1011,
    ALU_SLA     = 4'b1100,
    ALU_SRA     = 4'b1101,
    ALU_PASSB   = 4'b1110,
    ALU_ILLEGAL = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } seq_state_e;

  function automatic logic is_muldiv(input logic [3:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] ctrl);
    return (ctrl == ALU_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the three buses around the sequencer:
//   request  : In_ReqValid/Out_ReqReady, In_Opcode, In_RegA, In_RegB, In_Imm
//   ALU side : Out_A, Out_B, Out_ALUCtrl (to ALU), In_ALUResult, In_Zero (from ALU)
//   response : Out_RespValid/In_RespReady, Out_Result, Out_ZeroFlag, Out_Err
//   status   : Out_Busy
// slave  = the sequencer; master = register-read stage, ALU and writeback.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             In_ReqValid;
  logic             Out_ReqReady;
  logic [4:0]       In_Opcode;
  logic [WIDTH-1:0] In_RegA;
  logic [WIDTH-1:0] In_RegB;
  logic [WIDTH-1:0] In_Imm;
  logic [WIDTH-1:0] Out_A;
  logic [WIDTH-1:0] Out_B;
  logic [3:0]       Out_ALUCtrl;
  logic [WIDTH-1:0] In_ALUResult;
  logic             In_Zero;
  logic             Out_RespValid;
  logic             In_RespReady;
  logic [WIDTH-1:0] Out_Result;
  logic             Out_ZeroFlag;
  logic             Out_Err;
  logic             Out_Busy;

  modport slave (
    input  In_ReqValid, In_Opcode, In_RegA, In_RegB, In_Imm,
    input  In_ALUResult, In_Zero, In_RespReady,
    output Out_ReqReady, Out_A, Out_B, Out_ALUCtrl,
    output Out_RespValid, Out_Result, Out_ZeroFlag, Out_Err, Out_Busy
  );

  modport master (
    output In_ReqValid, In_Opcode, In_RegA, In_RegB, In_Imm,
    output In_ALUResult, In_Zero, In_RespReady,
    input  Out_ReqReady, Out_A, Out_B, Out_ALUCtrl,
    input  Out_RespValid, Out_Result, Out_ZeroFlag, Out_Err, Out_Busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Issue-side counterpart of the 16-bit ALU. Accepts a decoded execute request,
// drives the ALU inputs from registers, holds them for one cycle (or
// MULDIV_CYCLES cycles for MUL/DIV), captures result and zero flag, and returns
// them over a valid/ready response handshake.
// Ports:
//   In_CLK    : clock, rising edge
//   In_Rst_N  : synchronous active-low reset
//   bus       : alu_op_sequencer_if.slave (request, ALU and response buses)
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int MULDIV_CYCLES = 3
) (
  input  logic              In_CLK,
  input  logic              In_Rst_N,
  alu_op_sequencer_if.slave bus
);

  // Counter value loaded on leaving ISSUE = number of WAIT cycles that follow.
  localparam logic [3:0] HOLD_LOAD  = 4'(MULDIV_CYCLES - 1);
  localparam logic       MULTI_HOLD = 1'(MULDIV_CYCLES > 1);

  seq_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [3:0]       hold_cnt_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;
  logic             busy_q;

  logic [WIDTH-1:0] opb_d;
  logic [3:0]       ctrl_d;
  logic             reject_d;

  // Operand B select and early rejection (illegal code or divide by zero)
  always_comb begin
    opb_d    = bus.In_RegB;
    ctrl_d   = bus.In_Opcode[3:0];
    reject_d = 1'b0;
    if (bus.In_Opcode[4]) begin
      opb_d = bus.In_Imm;
    end else begin
      opb_d = bus.In_RegB;
    end
    if (is_illegal(ctrl_d)) begin
      reject_d = 1'b1;
    end else if ((ctrl_d == ALU_DIV) && (opb_d == {WIDTH{1'b0}})) begin
      reject_d = 1'b1;
    end else begin
      reject_d = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge In_CLK) begin
    if (!In_Rst_N) begin
      state_q      <= ST_IDLE;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      ctrl_q       <= 4'd0;
      hold_cnt_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      result_q     <= {WIDTH{1'b0}};
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.In_ReqValid) begin
            busy_q <= 1'b1;
            if (reject_d) begin
              // Error response skips the ALU entirely; its inputs keep the last op.
              state_q      <= ST_RESP;
              result_q     <= {WIDTH{1'b1}};
              zero_q       <= 1'b0;
              err_q        <= 1'b1;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              a_q     <= bus.In_RegA;
              b_q     <= opb_d;
              ctrl_q  <= ctrl_d;
            end
          end
        end
        ST_ISSUE: begin
          if (is_muldiv(ctrl_q) && MULTI_HOLD) begin
            hold_cnt_q <= HOLD_LOAD;
            state_q    <= ST_WAIT;
          end else begin
            state_q      <= ST_RESP;
            result_q     <= bus.In_ALUResult;
            zero_q       <= bus.In_Zero;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Capture on the cycle the counter steps down to zero.
          hold_cnt_q <= hold_cnt_q - 4'd1;
          if (hold_cnt_q == 4'd1) begin
            state_q      <= ST_RESP;
            result_q     <= bus.In_ALUResult;
            zero_q       <= bus.In_Zero;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.In_RespReady) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Out_ReqReady  = (state_q == ST_IDLE) & In_Rst_N;
  assign bus.Out_A         = a_q;
  assign bus.Out_B         = b_q;
  assign bus.Out_ALUCtrl   = ctrl_q;
  assign bus.Out_RespValid = resp_valid_q;
  assign bus.Out_Result    = result_q;
  assign bus.Out_ZeroFlag  = zero_q;
  assign bus.Out_Err       = err_q;
  assign bus.Out_Busy      = busy_q;

endmodule
